// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg7_pkg
// Purpose  : Shared 7-segment patterns ({g,f,e,d,c,b,a}), the hex decode
//            table, scan-capture state encoding and digit-select helpers.
// Revision : 1.0  initial release
// ============================================================================
package seg7_pkg;

   localparam logic [6:0] SEG_0 = 7'h3F;
   localparam logic [6:0] SEG_1 = 7'h06;
   localparam logic [6:0] SEG_2 = 7'h5B;
   localparam logic [6:0] SEG_3 = 7'h4F;
   localparam logic [6:0] SEG_4 = 7'h66;
   localparam logic [6:0] SEG_5 = 7'h6D;
   localparam logic [6:0] SEG_6 = 7'h7D;
   localparam logic [6:0] SEG_7 = 7'h07;
   localparam logic [6:0] SEG_8 = 7'h7F;
   localparam logic [6:0] SEG_9 = 7'h6F;
   localparam logic [6:0] SEG_A = 7'h77;
   localparam logic [6:0] SEG_B = 7'h7C;
   localparam logic [6:0] SEG_C = 7'h39;
   localparam logic [6:0] SEG_D = 7'h5E;
   localparam logic [6:0] SEG_E = 7'h79;
   localparam logic [6:0] SEG_F = 7'h71;

   // Entry [v] holds the pattern for hex value v
   localparam logic [15:0][6:0] SEG_TABLE = {
      SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
      SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
   };

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_HELD   = 2'd2;

   // A digit is selected only when exactly one active-low enable is low
   function automatic logic sel_legal(input logic [3:0] an);
      return ($countones(~an) == 1);
   endfunction

   function automatic logic [1:0] sel_index(input logic [3:0] an);
      logic [1:0] idx;
      case (an)
         4'b1101: idx = 2'd1;
         4'b1011: idx = 2'd2;
         4'b0111: idx = 2'd3;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_scan_capture_if.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_capture_if
// Purpose  : Multiplexed 7-segment bus plus the captured-digit result bus.
//            Optional macro SEG7_DP_EN adds the decimal-point signals.
// Revision : 1.0  initial release
// ============================================================================
interface seg7_scan_capture_if;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        digit_valid;
   logic [1:0]  digit_idx;
   logic [3:0]  digit_val;
   logic        digit_err;
   logic [15:0] digits;
   logic        frame_done;
`ifdef SEG7_DP_EN
   logic        dp;
   logic        dp_val;
   logic [3:0]  digits_dp;

   modport master (output an, seg, dp,
                   input  digit_valid, digit_idx, digit_val, digit_err,
                          digits, frame_done, dp_val, digits_dp);
   modport slave  (input  an, seg, dp,
                   output digit_valid, digit_idx, digit_val, digit_err,
                          digits, frame_done, dp_val, digits_dp);
`else
   modport master (output an, seg,
                   input  digit_valid, digit_idx, digit_val, digit_err,
                          digits, frame_done);
   modport slave  (input  an, seg,
                   output digit_valid, digit_idx, digit_val, digit_err,
                          digits, frame_done);
`endif
endinterface
`default_nettype wire

// File: rtl/seg7_pattern_decode.sv
`default_nettype none
// ============================================================================
// Module   : seg7_pattern_decode
// Purpose  : Combinational 7-segment pattern to hex decoder; unknown patterns
//            (including blank) flag err and return value 0.
// Revision : 1.0  initial release
// ============================================================================
module seg7_pattern_decode
   import seg7_pkg::*;
(
   input  logic [6:0] seg_i,
   output logic       err_o,
   output logic [3:0] val_o
);

   // Search the shared table; patterns are unique so at most one entry hits
   always_comb begin
      err_o = 1'b1;
      val_o = 4'h0;
      for (int i = 0; i < 16; i++) begin
         if (seg_i == SEG_TABLE[i[3:0]]) begin
            err_o = 1'b0;
            val_o = i[3:0];
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_capture.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_capture
// Purpose  : Samples a multiplexed 4-digit 7-segment bus, waits for each
//            digit pattern to be stable, decodes it and assembles a frame.
//            Optional macro SEG7_DP_EN also captures the decimal point.
// Revision : 1.0  initial release
// ============================================================================
module seg7_scan_capture
   import seg7_pkg::*;
#(
   parameter int STABLE_CYCLES  = 4,
   parameter int CNT_W          = 8,
   parameter bit SEG_ACTIVE_LOW = 1'b0
)(
   input  logic                clk,
   input  logic                rst,
   seg7_scan_capture_if.slave  bus
);

   localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef SEG7_DP_EN
   localparam int SMP_W = 12;
`else
   localparam int SMP_W = 11;
`endif

   logic [6:0]       seg_in;
   logic [SMP_W-1:0] smp_d, smp_q;
   logic             sel_ok, changed;
   logic [1:0]       sel_idx;
   logic             dec_err;
   logic [3:0]       dec_val;

   logic [1:0]       state_d, state_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;
   logic             capture;
   logic [3:0]       mask_q, mask_nxt;

   logic             valid_q, err_q, frame_q;
   logic [1:0]       idx_q;
   logic [3:0]       val_q;
   logic [15:0]      digits_q;
`ifdef SEG7_DP_EN
   logic             dp_val_q;
   logic [3:0]       digits_dp_q;
`endif

   assign seg_in = SEG_ACTIVE_LOW ? ~bus.seg : bus.seg;
`ifdef SEG7_DP_EN
   assign smp_d = {bus.dp, bus.an, seg_in};
`else
   assign smp_d = {bus.an, seg_in};
`endif
   assign sel_ok   = sel_legal(bus.an);
   assign sel_idx  = sel_index(bus.an);
   assign changed  = (smp_d != smp_q);
   assign mask_nxt = mask_q | (4'b0001 << sel_idx);

   seg7_pattern_decode u_decode (
      .seg_i (seg_in),
      .err_o (dec_err),
      .val_o (dec_val)
   );

   // Next state and stability count, judged on the sample taken at this edge
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      capture = 1'b0;
      if (!sel_ok) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_SETTLE: begin
               if (changed)                cnt_d = CNT_ONE;
               else if (cnt_q < STABLE_C)  cnt_d = cnt_q + CNT_ONE;
            end
            ST_HELD: begin
               if (changed) begin
                  state_d = ST_SETTLE;
                  cnt_d   = CNT_ONE;
               end
            end
            default: begin
               state_d = ST_SETTLE;
               cnt_d   = CNT_ONE;
            end
         endcase
         // Reaching the threshold captures on this same edge
         if (state_d == ST_SETTLE && cnt_d >= STABLE_C) begin
            capture = 1'b1;
            state_d = ST_HELD;
         end
      end
   end

   // State, counter, frame mask and registered result outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         smp_q       <= '0;
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         mask_q      <= '0;
         valid_q     <= 1'b0;
         err_q       <= 1'b0;
         frame_q     <= 1'b0;
         idx_q       <= '0;
         val_q       <= '0;
         digits_q    <= '0;
`ifdef SEG7_DP_EN
         dp_val_q    <= 1'b0;
         digits_dp_q <= '0;
`endif
      end else begin
         smp_q   <= smp_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         valid_q <= capture;
         frame_q <= 1'b0;
         if (capture) begin
            idx_q <= sel_idx;
            err_q <= dec_err;
            val_q <= dec_err ? 4'h0 : dec_val;
`ifdef SEG7_DP_EN
            dp_val_q <= bus.dp;
`endif
            // Error captures leave the frame contents and mask untouched
            if (!dec_err) begin
               digits_q[{sel_idx, 2'b00} +: 4] <= dec_val;
`ifdef SEG7_DP_EN
               digits_dp_q[sel_idx] <= bus.dp;
`endif
               if (mask_nxt == 4'hF) begin
                  frame_q <= 1'b1;
                  mask_q  <= '0;
               end else begin
                  mask_q  <= mask_nxt;
               end
            end
         end
      end
   end

   assign bus.digit_valid = valid_q;
   assign bus.digit_idx   = idx_q;
   assign bus.digit_val   = val_q;
   assign bus.digit_err   = err_q;
   assign bus.digits      = digits_q;
   assign bus.frame_done  = frame_q;
`ifdef SEG7_DP_EN
   assign bus.dp_val      = dp_val_q;
   assign bus.digits_dp   = digits_dp_q;
`endif

endmodule
`default_nettype wire
